bp_be_csr_responder: RTL and testbench

BP_BE_CSR_RESPONDER -- requirements
Module: bp_be_csr_responder

---
 rtl/bp_be_pkg.sv | 67 ++++++
 rtl/bp_be_csr_responder_if.sv | 38 +++
 rtl/bp_be_tlb_fill_fsm.sv | 78 +++++++
 rtl/bp_be_csr_responder.sv | 160 ++++++++++++++++
 tb/tb_bp_be_csr_responder.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_be_pkg.sv
// Shared types and constants for the backend CSR responder: configs, CSR addresses,
// mcause codes, the command struct and the TLB fill FSM states.
package bp_be_pkg;

  typedef enum logic {
    e_bp_inv_cfg,
    e_bp_sv48_cfg
  } bp_params_e;

  localparam int unsigned dword_width = 64;

  function automatic int unsigned vaddr_width_f(bp_params_e cfg);
    case (cfg)
      e_bp_sv48_cfg: return 48;
      default:       return 39;
    endcase
  endfunction

  typedef enum logic [3:0] {
    e_csrrw,
    e_csrrs,
    e_csrrc,
    e_csrrwi,
    e_csrrsi,
    e_csrrci,
    e_mret,
    e_itlb_fill,
    e_dtlb_fill,
    e_load_misaligned,
    e_load_access,
    e_store_misaligned,
    e_store_access,
    e_instr_pf,
    e_load_pf,
    e_store_pf
  } bp_be_csr_op_e;

  typedef struct packed {
    bp_be_csr_op_e            csr_op;
    logic [11:0]              csr_addr;
    logic [dword_width-1:0]   data;
  } bp_be_csr_cmd_s;

  localparam int unsigned csr_cmd_width = $bits(bp_be_csr_cmd_s);

  localparam logic [11:0] csr_addr_mtvec    = 12'h305;
  localparam logic [11:0] csr_addr_mscratch = 12'h340;
  localparam logic [11:0] csr_addr_mepc     = 12'h341;
  localparam logic [11:0] csr_addr_mcause   = 12'h342;
  localparam logic [11:0] csr_addr_mtval    = 12'h343;
  localparam logic [11:0] csr_addr_satp     = 12'h180;

  localparam logic [dword_width-1:0] ecode_load_misaligned  = 64'd4;
  localparam logic [dword_width-1:0] ecode_load_access      = 64'd5;
  localparam logic [dword_width-1:0] ecode_store_misaligned = 64'd6;
  localparam logic [dword_width-1:0] ecode_store_access     = 64'd7;
  localparam logic [dword_width-1:0] ecode_instr_pf         = 64'd12;
  localparam logic [dword_width-1:0] ecode_load_pf          = 64'd13;
  localparam logic [dword_width-1:0] ecode_store_pf         = 64'd15;

  typedef enum logic [1:0] {
    e_ready,
    e_fill_req,
    e_fill_wait
  } bp_be_fill_state_e;

endpackage

// File: rtl/bp_be_csr_responder_if.sv
// Command, page-walk and redirect signals between the backend and the CSR responder.
interface bp_be_csr_responder_if
  import bp_be_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_inv_cfg
);
  localparam int unsigned vaddr_width = vaddr_width_f(bp_params_p);

  bp_be_csr_cmd_s           csr_cmd_i;
  logic                     csr_cmd_v_i;
  logic [vaddr_width-1:0]   exc_pc_i;
  logic                     ready_o;
  logic [dword_width-1:0]   csr_data_o;
  logic                     csr_exc_o;
  logic                     ptw_req_v_o;
  logic [vaddr_width-1:0]   ptw_req_vaddr_o;
  logic                     ptw_req_itlb_o;
  logic                     ptw_req_ready_i;
  logic                     ptw_done_i;
  logic                     ptw_fault_i;
  logic                     trap_v_o;
  logic [vaddr_width-1:0]   trap_pc_o;
  logic                     ret_v_o;
  logic [vaddr_width-1:0]   ret_pc_o;

  modport slave (
    input  csr_cmd_i, csr_cmd_v_i, exc_pc_i, ptw_req_ready_i, ptw_done_i, ptw_fault_i,
    output ready_o, csr_data_o, csr_exc_o, ptw_req_v_o, ptw_req_vaddr_o, ptw_req_itlb_o,
           trap_v_o, trap_pc_o, ret_v_o, ret_pc_o
  );

  modport master (
    output csr_cmd_i, csr_cmd_v_i, exc_pc_i, ptw_req_ready_i, ptw_done_i, ptw_fault_i,
    input  ready_o, csr_data_o, csr_exc_o, ptw_req_v_o, ptw_req_vaddr_o, ptw_req_itlb_o,
           trap_v_o, trap_pc_o, ret_v_o, ret_pc_o
  );

endinterface

// File: rtl/bp_be_tlb_fill_fsm.sv
// TLB fill sequencer: latches a fill request, issues it to the page walker and reports
// a walk fault back so the responder can raise a page-fault trap.
module bp_be_tlb_fill_fsm
  import bp_be_pkg::*;
#(
  parameter int unsigned vaddr_width = 39
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   start_v_i,
  input  logic                   start_itlb_i,
  input  logic [vaddr_width-1:0] start_vaddr_i,
  input  logic [vaddr_width-1:0] start_pc_i,
  input  logic                   ptw_req_ready_i,
  input  logic                   ptw_done_i,
  input  logic                   ptw_fault_i,
  output logic                   ready_o,
  output logic                   ptw_req_v_o,
  output logic [vaddr_width-1:0] ptw_req_vaddr_o,
  output logic                   ptw_req_itlb_o,
  output logic                   fault_v_o,
  output logic                   fault_itlb_o,
  output logic [vaddr_width-1:0] fault_vaddr_o,
  output logic [vaddr_width-1:0] fault_pc_o
);

  bp_be_fill_state_e      state_d, state_q;
  logic [vaddr_width-1:0] vaddr_d, vaddr_q;
  logic [vaddr_width-1:0] pc_d, pc_q;
  logic                   itlb_d, itlb_q;

  always_comb begin
    state_d = state_q;
    vaddr_d = vaddr_q;
    pc_d    = pc_q;
    itlb_d  = itlb_q;
    unique case (state_q)
      e_ready: begin
        if (start_v_i) begin
          vaddr_d = start_vaddr_i;
          pc_d    = start_pc_i;
          itlb_d  = start_itlb_i;
          state_d = e_fill_req;
        end
      end
      e_fill_req:  if (ptw_req_ready_i) state_d = e_fill_wait;
      e_fill_wait: if (ptw_done_i) state_d = e_ready;
      default:     state_d = e_ready;
    endcase
  end

  // Outputs are masked during reset so nothing leaks out while the fill is being aborted.
  always_comb begin
    ready_o         = (state_q == e_ready) & ~reset_i;
    ptw_req_v_o     = (state_q == e_fill_req) & ~reset_i;
    ptw_req_vaddr_o = vaddr_q;
    ptw_req_itlb_o  = itlb_q;
    fault_v_o       = (state_q == e_fill_wait) & ptw_done_i & ptw_fault_i & ~reset_i;
    fault_itlb_o    = itlb_q;
    fault_vaddr_o   = vaddr_q;
    fault_pc_o      = pc_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_ready;
      vaddr_q <= '0;
      pc_q    <= '0;
      itlb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vaddr_q <= vaddr_d;
      pc_q    <= pc_d;
      itlb_q  <= itlb_d;
    end
  end

endmodule

// File: rtl/bp_be_csr_responder.sv
// Machine-mode CSR file with trap/mret redirect and a TLB fill sequencer.
module bp_be_csr_responder
  import bp_be_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_inv_cfg
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  bp_be_csr_responder_if.slave        bus
);

  localparam int unsigned vaddr_width = vaddr_width_f(bp_params_p);

  bp_be_csr_cmd_s cmd;
  assign cmd = bus.csr_cmd_i;

  logic [dword_width-1:0] mtvec_d, mtvec_q, mscratch_d, mscratch_q;
  logic [dword_width-1:0] mcause_d, mcause_q, mtval_d, mtval_q, satp_d, satp_q;
  logic [vaddr_width-1:0] mepc_d, mepc_q;
  logic                   trap_d, trap_q, ret_d, ret_q;

  logic                   fill_ready, accept, is_csr, is_fault, is_fill, is_setclr;
  logic                   implemented, csr_wr;
  logic [dword_width-1:0] old_val, wr_val, fault_cause;
  logic                   fill_fault_v, fill_fault_itlb;
  logic [vaddr_width-1:0] fill_fault_vaddr, fill_fault_pc;
  logic [vaddr_width-1:0] ptw_req_vaddr;
  logic                   ptw_req_v, ptw_req_itlb;

  assign accept = bus.csr_cmd_v_i & fill_ready & ~reset_i;

  always_comb begin
    is_csr    = cmd.csr_op inside {e_csrrw, e_csrrs, e_csrrc, e_csrrwi, e_csrrsi, e_csrrci};
    is_setclr = cmd.csr_op inside {e_csrrs, e_csrrc, e_csrrsi, e_csrrci};
    is_fill   = cmd.csr_op inside {e_itlb_fill, e_dtlb_fill};
    is_fault  = cmd.csr_op inside {e_load_misaligned, e_load_access, e_store_misaligned,
                                   e_store_access, e_instr_pf, e_load_pf, e_store_pf};

    implemented = 1'b1;
    old_val     = '0;
    case (cmd.csr_addr)
      csr_addr_mtvec:    old_val = mtvec_q;
      csr_addr_mscratch: old_val = mscratch_q;
      csr_addr_mepc:     old_val = {{(dword_width-vaddr_width){1'b0}}, mepc_q};
      csr_addr_mcause:   old_val = mcause_q;
      csr_addr_mtval:    old_val = mtval_q;
      csr_addr_satp:     old_val = satp_q;
      default:           implemented = 1'b0;
    endcase

    case (cmd.csr_op)
      e_csrrs, e_csrrsi: wr_val = old_val | cmd.data;
      e_csrrc, e_csrrci: wr_val = old_val & ~cmd.data;
      default:           wr_val = cmd.data;
    endcase

    case (cmd.csr_op)
      e_load_misaligned:  fault_cause = ecode_load_misaligned;
      e_load_access:      fault_cause = ecode_load_access;
      e_store_misaligned: fault_cause = ecode_store_misaligned;
      e_store_access:     fault_cause = ecode_store_access;
      e_instr_pf:         fault_cause = ecode_instr_pf;
      e_load_pf:          fault_cause = ecode_load_pf;
      default:            fault_cause = ecode_store_pf;
    endcase

    // Set/clear with a zero mask is a pure read and must not disturb the register.
    csr_wr = accept & is_csr & implemented & ~(is_setclr & (cmd.data == '0));
  end

  always_comb begin
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    satp_d     = satp_q;
    if (csr_wr) begin
      case (cmd.csr_addr)
        csr_addr_mtvec:    mtvec_d    = wr_val;
        csr_addr_mscratch: mscratch_d = wr_val;
        csr_addr_mepc:     mepc_d     = wr_val[vaddr_width-1:0];
        csr_addr_mcause:   mcause_d   = wr_val;
        csr_addr_mtval:    mtval_d    = wr_val;
        csr_addr_satp:     satp_d     = wr_val;
        default:           ;
      endcase
    end
    if (accept & is_fault) begin
      mcause_d = fault_cause;
      mtval_d  = cmd.data;
      mepc_d   = bus.exc_pc_i;
    end
    if (fill_fault_v) begin
      mcause_d = fill_fault_itlb ? ecode_instr_pf : ecode_load_pf;
      mtval_d  = {{(dword_width-vaddr_width){1'b0}}, fill_fault_vaddr};
      mepc_d   = fill_fault_pc;
    end
    trap_d = (accept & is_fault) | fill_fault_v;
    ret_d  = accept & (cmd.csr_op == e_mret);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      satp_q     <= '0;
      trap_q     <= 1'b0;
      ret_q      <= 1'b0;
    end else begin
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      satp_q     <= satp_d;
      trap_q     <= trap_d;
      ret_q      <= ret_d;
    end
  end

  bp_be_tlb_fill_fsm #(
    .vaddr_width(vaddr_width)
  ) fill_fsm (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .start_v_i      (accept & is_fill),
    .start_itlb_i   (cmd.csr_op == e_itlb_fill),
    .start_vaddr_i  (cmd.data[vaddr_width-1:0]),
    .start_pc_i     (bus.exc_pc_i),
    .ptw_req_ready_i(bus.ptw_req_ready_i),
    .ptw_done_i     (bus.ptw_done_i),
    .ptw_fault_i    (bus.ptw_fault_i),
    .ready_o        (fill_ready),
    .ptw_req_v_o    (ptw_req_v),
    .ptw_req_vaddr_o(ptw_req_vaddr),
    .ptw_req_itlb_o (ptw_req_itlb),
    .fault_v_o      (fill_fault_v),
    .fault_itlb_o   (fill_fault_itlb),
    .fault_vaddr_o  (fill_fault_vaddr),
    .fault_pc_o     (fill_fault_pc)
  );

  always_comb begin
    bus.ready_o         = fill_ready;
    bus.csr_data_o      = (accept & is_csr & implemented) ? old_val : '0;
    bus.csr_exc_o       = accept & is_csr & ~implemented;
    bus.ptw_req_v_o     = ptw_req_v;
    bus.ptw_req_vaddr_o = ptw_req_vaddr;
    bus.ptw_req_itlb_o  = ptw_req_itlb;
    bus.trap_v_o        = trap_q;
    bus.trap_pc_o       = {mtvec_q[vaddr_width-1:2], 2'b00};
    bus.ret_v_o         = ret_q;
    bus.ret_pc_o        = mepc_q;
  end

endmodule

// File: tb/tb_bp_be_csr_responder.sv
// Directed bench for bp_be_csr_responder; expected values go through a scoreboard queue.
module tb_bp_be_csr_responder;
  import bp_be_pkg::*;

  localparam int unsigned VA = vaddr_width_f(e_bp_inv_cfg);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bp_be_csr_responder_if #(.bp_params_p(e_bp_inv_cfg)) bus ();

  bp_be_csr_responder #(.bp_params_p(e_bp_inv_cfg)) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .bus    (bus)
  );

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic push(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [63:0] obs);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty observed=%0h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val)
      else begin
        miscompares++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input bp_be_csr_op_e op, input logic [11:0] a, input logic [63:0] d,
                     input logic [63:0] pc);
    bus.csr_cmd_i.csr_op   = op;
    bus.csr_cmd_i.csr_addr = a;
    bus.csr_cmd_i.data     = d;
    bus.exc_pc_i           = pc[VA-1:0];
    bus.csr_cmd_v_i        = 1'b1;
  endtask

  task automatic idle();
    bus.csr_cmd_v_i = 1'b0;
  endtask

  task automatic read_csr(input logic [11:0] a, input logic [63:0] exp, input string tag);
    cmd(e_csrrs, a, 64'h0, 64'h0);
    push(tag, exp);
    @(negedge clk);
    chk(bus.csr_data_o);
    cyc();
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset               = 1'b1;
    bus.csr_cmd_i       = '0;
    bus.csr_cmd_v_i     = 1'b0;
    bus.exc_pc_i        = '0;
    bus.ptw_req_ready_i = 1'b0;
    bus.ptw_done_i      = 1'b0;
    bus.ptw_fault_i     = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;

    // Post-reset state
    push("rst_ready", 64'h1);
    push("rst_trap", 64'h0);
    push("rst_ret", 64'h0);
    push("rst_ptw_v", 64'h0);
    @(negedge clk);
    chk(64'(bus.ready_o));
    chk(64'(bus.trap_v_o));
    chk(64'(bus.ret_v_o));
    chk(64'(bus.ptw_req_v_o));
    cyc();

    // mscratch read-modify-write sequence
    cmd(e_csrrw, 12'h340, 64'hDEAD, 64'h0);
    push("rw_old", 64'h0);
    @(negedge clk);
    chk(bus.csr_data_o);
    cyc();
    cmd(e_csrrs, 12'h340, 64'h0F0, 64'h0);
    push("rs_old", 64'hDEAD);
    @(negedge clk);
    chk(bus.csr_data_o);
    cyc();
    idle();
    read_csr(12'h340, 64'hDEFD, "rs_result");
    cmd(e_csrrc, 12'h340, 64'hF00, 64'h0);
    push("rc_old", 64'hDEFD);
    @(negedge clk);
    chk(bus.csr_data_o);
    cyc();
    idle();
    read_csr(12'h340, 64'hD0FD, "rc_result");

    // Immediate write to satp
    cmd(e_csrrwi, 12'h180, 64'h1F, 64'h0);
    push("satp_old", 64'h0);
    @(negedge clk);
    chk(bus.csr_data_o);
    cyc();
    idle();
    read_csr(12'h180, 64'h1F, "satp_new");

    // Unimplemented CSR
    cmd(e_csrrw, 12'h7C0, 64'hFFFF, 64'h0);
    push("bad_exc", 64'h1);
    push("bad_data", 64'h0);
    @(negedge clk);
    chk(64'(bus.csr_exc_o));
    chk(bus.csr_data_o);
    cyc();
    idle();
    push("exc_clear", 64'h0);
    @(negedge clk);
    chk(64'(bus.csr_exc_o));
    cyc();
    read_csr(12'h340, 64'hD0FD, "bad_nochange");

    // Synchronous fault trap
    cmd(e_csrrw, 12'h305, 64'h8000_0003, 64'h0);
    push("mtvec_old", 64'h0);
    @(negedge clk);
    chk(bus.csr_data_o);
    cyc();
    cmd(e_load_pf, 12'h0, 64'h1234, 64'h400);
    push("fault_trap_early", 64'h0);
    @(negedge clk);
    chk(64'(bus.trap_v_o));
    cyc();
    cmd(e_csrrs, 12'h342, 64'h0, 64'h0);
    push("fault_trap_v", 64'h1);
    push("fault_trap_pc", 64'h8000_0000);
    push("fault_mcause", 64'd13);
    @(negedge clk);
    chk(64'(bus.trap_v_o));
    chk(64'(bus.trap_pc_o));
    chk(bus.csr_data_o);
    cyc();
    cmd(e_csrrs, 12'h343, 64'h0, 64'h0);
    push("fault_trap_once", 64'h0);
    push("fault_mtval", 64'h1234);
    @(negedge clk);
    chk(64'(bus.trap_v_o));
    chk(bus.csr_data_o);
    cyc();
    idle();
    read_csr(12'h341, 64'h400, "fault_mepc");
    read_csr(12'h305, 64'h8000_0003, "mtvec_full");

    // ITLB fill with stalled page walker and a faulting walk
    cmd(e_itlb_fill, 12'h0, 64'h5000, 64'h700);
    push("fill_accept_ready", 64'h1);
    @(negedge clk);
    chk(64'(bus.ready_o));
    cyc();
    idle();
    for (int i = 0; i < 3; i++) begin
      push("fill_req_v_stall", 64'h1);
      push("fill_ready_stall", 64'h0);
      @(negedge clk);
      chk(64'(bus.ptw_req_v_o));
      chk(64'(bus.ready_o));
      cyc();
    end
    bus.ptw_req_ready_i = 1'b1;
    push("fill_req_v_hs", 64'h1);
    push("fill_req_vaddr", 64'h5000);
    push("fill_req_itlb", 64'h1);
    push("fill_ready_hs", 64'h0);
    @(negedge clk);
    chk(64'(bus.ptw_req_v_o));
    chk(64'(bus.ptw_req_vaddr_o));
    chk(64'(bus.ptw_req_itlb_o));
    chk(64'(bus.ready_o));
    cyc();
    bus.ptw_req_ready_i = 1'b0;
    cmd(e_csrrw, 12'h340, 64'h1111, 64'h0);
    push("wait_req_v", 64'h0);
    push("wait_ready", 64'h0);
    @(negedge clk);
    chk(64'(bus.ptw_req_v_o));
    chk(64'(bus.ready_o));
    cyc();
    idle();
    bus.ptw_done_i  = 1'b1;
    bus.ptw_fault_i = 1'b1;
    push("done_ready", 64'h0);
    @(negedge clk);
    chk(64'(bus.ready_o));
    cyc();
    bus.ptw_done_i  = 1'b0;
    bus.ptw_fault_i = 1'b0;
    cmd(e_csrrs, 12'h342, 64'h0, 64'h0);
    push("fill_trap_v", 64'h1);
    push("fill_ready_back", 64'h1);
    push("fill_mcause", 64'd12);
    @(negedge clk);
    chk(64'(bus.trap_v_o));
    chk(64'(bus.ready_o));
    chk(bus.csr_data_o);
    cyc();
    idle();
    read_csr(12'h343, 64'h5000, "fill_mtval");
    read_csr(12'h341, 64'h700, "fill_mepc");
    read_csr(12'h340, 64'hD0FD, "ignored_cmd");

    // Reset during fill wait aborts it
    cmd(e_dtlb_fill, 12'h0, 64'h6000, 64'h800);
    cyc();
    idle();
    bus.ptw_req_ready_i = 1'b1;
    push("abort_req_v", 64'h1);
    @(negedge clk);
    chk(64'(bus.ptw_req_v_o));
    cyc();
    bus.ptw_req_ready_i = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    bus.ptw_done_i  = 1'b1;
    bus.ptw_fault_i = 1'b1;
    push("abort_ready", 64'h1);
    push("abort_req_v_low", 64'h0);
    @(negedge clk);
    chk(64'(bus.ready_o));
    chk(64'(bus.ptw_req_v_o));
    cyc();
    bus.ptw_done_i  = 1'b0;
    bus.ptw_fault_i = 1'b0;
    push("abort_no_trap", 64'h0);
    @(negedge clk);
    chk(64'(bus.trap_v_o));
    cyc();
    read_csr(12'h305, 64'h0, "abort_mtvec");
    read_csr(12'h340, 64'h0, "abort_mscratch");
    read_csr(12'h341, 64'h0, "abort_mepc");
    read_csr(12'h342, 64'h0, "abort_mcause");
    read_csr(12'h343, 64'h0, "abort_mtval");
    read_csr(12'h180, 64'h0, "abort_satp");

    // mret redirect
    cmd(e_csrrw, 12'h341, 64'h900, 64'h0);
    push("mepc_set_old", 64'h0);
    @(negedge clk);
    chk(bus.csr_data_o);
    cyc();
    cmd(e_mret, 12'h0, 64'h0, 64'h0);
    push("mret_early", 64'h0);
    @(negedge clk);
    chk(64'(bus.ret_v_o));
    cyc();
    idle();
    push("mret_v", 64'h1);
    push("mret_pc", 64'h900);
    @(negedge clk);
    chk(64'(bus.ret_v_o));
    chk(64'(bus.ret_pc_o));
    cyc();
    push("mret_once", 64'h0);
    @(negedge clk);
    chk(64'(bus.ret_v_o));
    cyc();

    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
